result_checker: RTL
===================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning observed/expected data width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning expected-value table entries (power of two).
REQ-003 SHALL have parameter AW, default 4, meaning table address width, log2(DEPTH).
REQ-004 SHALL have parameter INTERVAL, default 2, meaning clock cycles between samples (>=1).
REQ-005 SHALL have parameter GATED, default 1, meaning 1 = skip compare when obs_gate is zero; 0 = always compare.
REQ-006 SHALL have port clock  input  1  the single clock; all logic on rising edge.
REQ-007 SHALL have port ctrl_reset  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port load_en  input  1  table write strobe.
REQ-009 SHALL have port load_addr  input  AW  table write index.
REQ-010 SHALL have port load_data  input  WIDTH  expected value to write.
REQ-011 SHALL have port start  input  1  begin a check run.
REQ-012 SHALL have port num_checks  input  AW+1  entries to check, latched at start, legal 0..DEPTH.
REQ-013 SHALL have port obs_gate  input  WIDTH  gating value (e.g. readRegA).
REQ-014 SHALL have port obs_data  input  WIDTH  observed value (e.g. readRegB).
REQ-015 SHALL have port busy  output  1  run in progress.
REQ-016 SHALL have port done  output  1  run finished, held until next start or reset.
REQ-017 SHALL have port pass  output  1  done with zero errors.
REQ-018 SHALL have port err_count  output  AW+1  mismatches this run, saturating.
REQ-019 SHALL have port err_strobe  output  1  one-cycle pulse after each mismatch.
REQ-020 SHALL have port err_index  output  AW  index of most recent mismatch.
REQ-021 SHALL have port first_err_index / first_err_exp / first_err_obs  output  AW / WIDTH / WIDTH  capture of first mismatch of the run.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-023 SHALL write load_data to table[load_addr] at an edge with load_en=1 in IDLE or DONE; load_en in RUN ignored.
REQ-024 SHALL, at an edge with start=1 in IDLE or DONE, latch num_checks, clear idx, tick, err_count, err_strobe, first_err_* and done/pass; go to RUN, or directly to DONE with pass=1 if num_checks=0.
REQ-025 SHALL ignore start while in RUN.
REQ-026 SHALL, in RUN, increment tick each edge; at the edge where tick=INTERVAL-1, compare obs_data against table[idx], reset tick to 0, increment idx.
REQ-027 SHALL treat a compare as a mismatch when obs_data != table[idx] and (GATED=0 or obs_gate != 0).
REQ-028 SHALL on mismatch: pulse err_strobe the following cycle, set err_index=idx, increment err_count saturating at 2^(AW+1)-1, and capture first_err_* only if err_count was 0.
REQ-029 SHALL transition RUN->DONE at the compare edge of idx=num_checks-1; done rises at that edge, so the first compare is INTERVAL edges and done is num_checks*INTERVAL edges after the start edge.
REQ-030 SHALL set pass=1 in DONE iff err_count=0, including a mismatch on the final compare.
REQ-031 SHALL give load/compare to the same address in the same cycle no interaction (load blocked in RUN).
REQ-032 SHALL clamp num_checks > DEPTH to DEPTH.

Reset
REQ-033 SHALL on ctrl_reset=1 at an edge enter IDLE and clear busy, done, pass, err_count, err_strobe, err_index, first_err_*, idx, tick; table contents retained.
REQ-034 SHALL give reset priority over start and load_en, including mid-run abort with no done pulse.

Verification
REQ-035 Load 5,3,8,2,0,1,3,20,4,345,567,345,567 to 0..12, num_checks=13, INTERVAL=2, obs matches, obs_gate=1 -> done 26 edges after start, pass=1, err_count=0.
REQ-036 Same, obs_data=21 at index 7 -> one err_strobe pulse, err_count=1, first_err_index=7, first_err_exp=20, first_err_obs=21, pass=0.
REQ-037 GATED=1, obs_gate=0 while obs_data=99 at index 2 -> no error, pass=1; GATED=0 same stimulus -> err_count=1.
REQ-038 num_checks=0, start -> done=1 and pass=1 the next cycle, busy never asserted.
REQ-039 ctrl_reset at index 5 of a run -> IDLE next cycle, all outputs 0; new start reruns from index 0 with prior table intact.
REQ-040 AW=2, all DEPTH=4 entries mismatched twice over two runs -> err_count=4 per run, cleared at second start; start during RUN ignored.

Source files
------------

// File: rtl/result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : result_checker
//  Description : Compares a sampled observation bus against a preloaded table
//                of expected values, one entry every INTERVAL clocks, and
//                reports mismatch count, per-mismatch strobe/index, a capture
//                of the first mismatch, and an overall pass flag.
//  Revision    : 1.0  initial release
// ============================================================================
module result_checker #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int INTERVAL = 2,
    parameter int GATED    = 1
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [AW:0]      num_checks,
    input  logic [WIDTH-1:0] obs_gate,
    input  logic [WIDTH-1:0] obs_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      err_count,
    output logic             err_strobe,
    output logic [AW-1:0]    err_index,
    output logic [AW-1:0]    first_err_index,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_obs
);

    // Tick counter needs at least one bit even when INTERVAL is 1.
    localparam int            TW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(INTERVAL - 1);
    localparam logic [AW:0]   CNT_MAX   = '1;
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      limit_q, limit_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [AW:0]      err_count_q, err_count_d;
    logic             err_strobe_q, err_strobe_d;
    logic [AW-1:0]    err_index_q, err_index_d;
    logic [AW-1:0]    first_err_index_q, first_err_index_d;
    logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
    logic [WIDTH-1:0] first_err_obs_q, first_err_obs_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] table_q [DEPTH];
    logic [WIDTH-1:0] expected_val;
    logic             table_we;
    logic             mismatch;
    logic             sample_now;
    logic             last_compare;
    logic             start_ok;

    // Table is frozen while a run is reading it, so a load can never race a compare.
    assign table_we     = load_en && !ctrl_reset && (state_q != S_RUN);
    assign expected_val = table_q[idx_q];
    assign mismatch     = (obs_data != expected_val) && ((GATED == 0) || (obs_gate != '0));
    assign sample_now   = (state_q == S_RUN) && (tick_q == TICK_LAST);
    assign last_compare = ({1'b0, idx_q} == (limit_q - 1'b1));
    assign start_ok     = start && (state_q != S_RUN);

    // Expected-value table write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (table_we) begin
            table_q[load_addr] <= load_data;
        end
    end

    // Next-state and run bookkeeping.
    always_comb begin
        state_d           = state_q;
        limit_d           = limit_q;
        idx_d             = idx_q;
        tick_d            = tick_q;
        err_count_d       = err_count_q;
        err_strobe_d      = 1'b0;
        err_index_d       = err_index_q;
        first_err_index_d = first_err_index_q;
        first_err_exp_d   = first_err_exp_q;
        first_err_obs_d   = first_err_obs_q;
        pass_d            = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    limit_d           = (num_checks > DEPTH_C) ? DEPTH_C : num_checks;
                    idx_d             = '0;
                    tick_d            = '0;
                    err_count_d       = '0;
                    first_err_index_d = '0;
                    first_err_exp_d   = '0;
                    first_err_obs_d   = '0;
                    // A zero-length run completes immediately and trivially passes.
                    if (num_checks == '0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                tick_d = tick_q + 1'b1;
                if (sample_now) begin
                    tick_d = '0;
                    idx_d  = idx_q + 1'b1;
                    if (mismatch) begin
                        err_strobe_d = 1'b1;
                        err_index_d  = idx_q;
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (err_count_q == '0) begin
                            first_err_index_d = idx_q;
                            first_err_exp_d   = expected_val;
                            first_err_obs_d   = obs_data;
                        end
                    end
                    // Pass uses the updated count so a final-entry mismatch is included.
                    if (last_compare) begin
                        state_d = S_DONE;
                        pass_d  = (err_count_d == '0);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q           <= S_IDLE;
            limit_q           <= '0;
            idx_q             <= '0;
            tick_q            <= '0;
            err_count_q       <= '0;
            err_strobe_q      <= 1'b0;
            err_index_q       <= '0;
            first_err_index_q <= '0;
            first_err_exp_q   <= '0;
            first_err_obs_q   <= '0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            limit_q           <= limit_d;
            idx_q             <= idx_d;
            tick_q            <= tick_d;
            err_count_q       <= err_count_d;
            err_strobe_q      <= err_strobe_d;
            err_index_q       <= err_index_d;
            first_err_index_q <= first_err_index_d;
            first_err_exp_q   <= first_err_exp_d;
            first_err_obs_q   <= first_err_obs_d;
            pass_q            <= pass_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign err_strobe      = err_strobe_q;
    assign err_index       = err_index_q;
    assign first_err_index = first_err_index_q;
    assign first_err_exp   = first_err_exp_q;
    assign first_err_obs   = first_err_obs_q;

endmodule
`default_nettype wire
